// File: rtl/st7789_rx_if.sv
// ST7789 pin bundle plus the decoded byte/pixel stream of the link receiver.
// The master side drives the panel pins; the slave side decodes them.
interface st7789_rx_if;
   logic        sda;
   logic        scl;
   logic        dc;
   logic        res;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_dc;
   logic        cmd_valid;
   logic        pix_valid;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_data;

   modport master (
      output sda, scl, dc, res,
      input  byte_valid, byte_data, byte_dc, cmd_valid,
      input  pix_valid, pix_x, pix_y, pix_data
   );

   modport slave (
      input  sda, scl, dc, res,
      output byte_valid, byte_data, byte_dc, cmd_valid,
      output pix_valid, pix_x, pix_y, pix_data
   );
endinterface

// File: rtl/st7789_rx.sv
// Receive-side model of the ST7789 serial link: deserializes SDA on SCL rise,
// decodes CASET/RASET/RAMWR and emits one RGB565 pixel write per pixel.
module st7789_rx #(
   parameter int unsigned WIDTH  = 240,
   parameter int unsigned HEIGHT = 240
) (
   input  logic         clk,
   input  logic         rst,
   st7789_rx_if.slave   bus
);
   localparam int unsigned CW = 9;
   localparam logic [CW-1:0] XE_RST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] YE_RST = CW'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CASET, S_RASET, S_RAMWR_HI, S_RAMWR_LO
   } state_t;

   // Pin synchronizers; scl_sync[2] is the previous synced SCL for edge detect.
   // These stay outside the pin reset so RES itself can be observed.
   logic [1:0] sda_sync, dc_sync, res_sync;
   logic [2:0] scl_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sda_sync <= 2'b00;
         dc_sync  <= 2'b00;
         res_sync <= 2'b00;
         scl_sync <= 3'b111;
      end else begin
         sda_sync <= {sda_sync[0], bus.sda};
         dc_sync  <= {dc_sync[0], bus.dc};
         res_sync <= {res_sync[0], bus.res};
         scl_sync <= {scl_sync[1:0], bus.scl};
      end
   end

   logic sda_s, dc_s, res_s, scl_rise;
   assign sda_s    = sda_sync[1];
   assign dc_s     = dc_sync[1];
   assign res_s    = res_sync[1];
   assign scl_rise = scl_sync[1] & ~scl_sync[2];

   // Deserializer
   logic [6:0] shift_q, shift_n;
   logic [2:0] cnt_q, cnt_n;
   logic       byte_valid_q, byte_valid_n;
   logic [7:0] byte_data_q, byte_data_n;
   logic       byte_dc_q, byte_dc_n;
   logic       cmd_valid_q, cmd_valid_n;

   always_comb begin
      shift_n      = shift_q;
      cnt_n        = cnt_q;
      byte_valid_n = 1'b0;
      cmd_valid_n  = 1'b0;
      byte_data_n  = byte_data_q;
      byte_dc_n    = byte_dc_q;
      if (scl_rise) begin
         shift_n = {shift_q[5:0], sda_s};
         cnt_n   = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            byte_valid_n = 1'b1;
            byte_data_n  = {shift_q, sda_s};
            byte_dc_n    = dc_s;
            cmd_valid_n  = ~dc_s;
         end
      end
      if (!res_s) begin
         shift_n     = '0;
         cnt_n       = '0;
         byte_data_n = '0;
         byte_dc_n   = 1'b0;
         cmd_valid_n = 1'b0;
         byte_valid_n = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q      <= '0;
         cnt_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_dc_q    <= 1'b0;
         cmd_valid_q  <= 1'b0;
      end else begin
         shift_q      <= shift_n;
         cnt_q        <= cnt_n;
         byte_valid_q <= byte_valid_n;
         byte_data_q  <= byte_data_n;
         byte_dc_q    <= byte_dc_n;
         cmd_valid_q  <= cmd_valid_n;
      end
   end

   // Command decoder and window pointer
   state_t          state_q, state_n;
   logic [1:0]      idx_q, idx_n;
   logic [23:0]     stage_q, stage_n;
   logic [CW-1:0]   xs_q, xs_n, xe_q, xe_n, ys_q, ys_n, ye_q, ye_n;
   logic [CW-1:0]   x_q, x_n, y_q, y_n;
   logic [7:0]      hi_q, hi_n;
   logic            pix_valid_q, pix_valid_n;
   logic [CW-1:0]   pix_x_q, pix_x_n, pix_y_q, pix_y_n;
   logic [15:0]     pix_data_q, pix_data_n;

   always_comb begin
      state_n     = state_q;
      idx_n       = idx_q;
      stage_n     = stage_q;
      xs_n        = xs_q;
      xe_n        = xe_q;
      ys_n        = ys_q;
      ye_n        = ye_q;
      x_n         = x_q;
      y_n         = y_q;
      hi_n        = hi_q;
      pix_valid_n = 1'b0;
      pix_x_n     = pix_x_q;
      pix_y_n     = pix_y_q;
      pix_data_n  = pix_data_q;

      if (byte_valid_q && !byte_dc_q) begin
         idx_n   = '0;
         stage_n = '0;
         case (byte_data_q)
            8'h2A:   state_n = S_CASET;
            8'h2B:   state_n = S_RASET;
            8'h2C: begin
               x_n     = xs_q;
               y_n     = ys_q;
               state_n = S_RAMWR_HI;
            end
            default: state_n = S_IDLE;
         endcase
      end else if (byte_valid_q) begin
         case (state_q)
            S_CASET, S_RASET: begin
               if (idx_q == 2'd3) begin
                  // Only the low 9 bits of start/end matter on a 9-bit grid
                  if (state_q == S_CASET) begin
                     xs_n = {stage_q[16], stage_q[15:8]};
                     xe_n = {stage_q[0], byte_data_q};
                  end else begin
                     ys_n = {stage_q[16], stage_q[15:8]};
                     ye_n = {stage_q[0], byte_data_q};
                  end
                  state_n = S_IDLE;
               end else begin
                  stage_n = {stage_q[15:0], byte_data_q};
                  idx_n   = idx_q + 2'd1;
               end
            end
            S_RAMWR_HI: begin
               hi_n    = byte_data_q;
               state_n = S_RAMWR_LO;
            end
            S_RAMWR_LO: begin
               pix_valid_n = 1'b1;
               pix_x_n     = x_q;
               pix_y_n     = y_q;
               pix_data_n  = {hi_q, byte_data_q};
               if (x_q == xe_q) begin
                  x_n = xs_q;
                  y_n = (y_q == ye_q) ? ys_q : y_q + 9'd1;
               end else begin
                  x_n = x_q + 9'd1;
               end
               state_n = S_RAMWR_HI;
            end
            default: ;
         endcase
      end

      if (!res_s) begin
         state_n     = S_IDLE;
         idx_n       = '0;
         stage_n     = '0;
         xs_n        = '0;
         xe_n        = XE_RST;
         ys_n        = '0;
         ye_n        = YE_RST;
         x_n         = '0;
         y_n         = '0;
         hi_n        = '0;
         pix_valid_n = 1'b0;
         pix_x_n     = '0;
         pix_y_n     = '0;
         pix_data_n  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         stage_q     <= '0;
         xs_q        <= '0;
         xe_q        <= XE_RST;
         ys_q        <= '0;
         ye_q        <= YE_RST;
         x_q         <= '0;
         y_q         <= '0;
         hi_q        <= '0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_data_q  <= '0;
      end else begin
         state_q     <= state_n;
         idx_q       <= idx_n;
         stage_q     <= stage_n;
         xs_q        <= xs_n;
         xe_q        <= xe_n;
         ys_q        <= ys_n;
         ye_q        <= ye_n;
         x_q         <= x_n;
         y_q         <= y_n;
         hi_q        <= hi_n;
         pix_valid_q <= pix_valid_n;
         pix_x_q     <= pix_x_n;
         pix_y_q     <= pix_y_n;
         pix_data_q  <= pix_data_n;
      end
   end

   assign bus.byte_valid = byte_valid_q;
   assign bus.byte_data  = byte_data_q;
   assign bus.byte_dc    = byte_dc_q;
   assign bus.cmd_valid  = cmd_valid_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_x      = pix_x_q;
   assign bus.pix_y      = pix_y_q;
   assign bus.pix_data   = pix_data_q;

endmodule

// File: tb/tb_st7789_rx.sv
// Directed bench for st7789_rx: bit-bangs the ST7789 pins and checks decoded
// bytes, commands and pixel writes against hand-computed values.
module tb_st7789_rx;
   logic clk;
   logic rst;

   st7789_rx_if bus ();

   st7789_rx #(.WIDTH(240), .HEIGHT(240)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled 1 time unit after each rising edge
   logic [33:0] pix_q[$];
   int          byte_cnt = 0;
   int          cmd_cnt  = 0;
   logic [7:0]  last_byte = '0;
   logic        last_dc   = 1'b0;

   always @(posedge clk) begin
      #1;
      if (bus.pix_valid) pix_q.push_back({bus.pix_x, bus.pix_y, bus.pix_data});
      if (bus.byte_valid) begin
         byte_cnt++;
         last_byte = bus.byte_data;
         last_dc   = bus.byte_dc;
      end
      if (bus.cmd_valid) cmd_cnt++;
   end

   task automatic send_bit(input logic d, input logic c);
      @(negedge clk);
      bus.scl = 1'b0;
      bus.sda = d;
      bus.dc  = c;
      repeat (4) @(negedge clk);
      bus.scl = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic c, input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i], c);
   endtask

   task automatic settle();
      repeat (8) @(negedge clk);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic check_pix(input string tag, input int i, input logic [8:0] x,
                            input logic [8:0] y, input logic [15:0] d);
      if (i < pix_q.size()) check(tag, 64'(pix_q[i]), 64'({x, y, d}));
      else check(tag, 64'(pix_q.size()), 64'(i + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]  wx[5];
      logic [8:0]  wy[5];
      logic [15:0] wd[5];
      int          c0, b0, n;
      logic [7:0]  lb;
      bit          found;

      bus.sda = 1'b0;
      bus.scl = 1'b1;
      bus.dc  = 1'b0;
      bus.res = 1'b1;
      rst     = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Reset values with SCL idling high
      check("rst_byte", 64'({bus.byte_valid, bus.byte_data, bus.byte_dc, bus.cmd_valid}), 64'(0));
      check("rst_pix", 64'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_data}), 64'(0));
      check("rst_no_pulses", 64'(byte_cnt + cmd_cnt + pix_q.size()), 64'(0));

      // Default window: RAMWR with two pixels
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'h00);
      send_byte(1'b1, 8'h11);
      send_byte(1'b1, 8'h22);
      send_byte(1'b1, 8'h33);
      settle();
      check("dflt_count", 64'(pix_q.size()), 64'(2));
      check_pix("dflt_pix0", 0, 9'd0, 9'd0, 16'h0011);
      check_pix("dflt_pix1", 1, 9'd1, 9'd0, 16'h2233);
      check("dflt_last_byte", 64'({last_byte, last_dc}), 64'({8'h33, 1'b1}));
      check("dflt_cmds", 64'(cmd_cnt), 64'(1));

      // Window write with wrap in both directions
      pix_q.delete();
      send_byte(1'b0, 8'h2A);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0B);
      send_byte(1'b0, 8'h2B);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
      send_byte(1'b0, 8'h2C);
      wd[0] = 16'hF800; wd[1] = 16'h07E0; wd[2] = 16'h001F; wd[3] = 16'hFFFF; wd[4] = 16'h1234;
      wx[0] = 9'd10; wx[1] = 9'd11; wx[2] = 9'd10; wx[3] = 9'd11; wx[4] = 9'd10;
      wy[0] = 9'd5;  wy[1] = 9'd5;  wy[2] = 9'd6;  wy[3] = 9'd6;  wy[4] = 9'd5;
      for (int i = 0; i < 5; i++) begin
         send_byte(1'b1, wd[i][15:8]);
         send_byte(1'b1, wd[i][7:0]);
      end
      settle();
      check("win_count", 64'(pix_q.size()), 64'(5));
      for (int i = 0; i < 5; i++) check_pix($sformatf("win_pix%0d", i), i, wx[i], wy[i], wd[i]);

      // Partial CASET aborted by NOP leaves the window alone
      pulse_rst();
      pix_q.delete();
      c0 = cmd_cnt;
      send_byte(1'b0, 8'h2A);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h14);
      send_byte(1'b0, 8'h00);
      settle();
      check("partial_cmds", 64'(cmd_cnt - c0), 64'(2));
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'h55); send_byte(1'b1, 8'h66);
      settle();
      check("partial_count", 64'(pix_q.size()), 64'(1));
      check_pix("partial_pix", 0, 9'd0, 9'd0, 16'h5566);

      // Half pixel dropped by a new RAMWR
      pix_q.delete();
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'hAB);
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'hCD); send_byte(1'b1, 8'hEF);
      settle();
      check("split_count", 64'(pix_q.size()), 64'(1));
      check_pix("split_pix", 0, 9'd0, 9'd0, 16'hCDEF);

      // RES pulse after 5 bits discards the partial byte and clears outputs
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
      @(negedge clk);
      bus.res = 1'b0;
      repeat (4) @(negedge clk);
      bus.res = 1'b1;
      repeat (6) @(negedge clk);
      check("res_pix_cleared", 64'({bus.pix_x, bus.pix_y, bus.pix_data}), 64'(0));
      b0 = byte_cnt;
      send_byte(1'b0, 8'h2A);
      settle();
      check("res_byte_count", 64'(byte_cnt - b0), 64'(1));
      check("res_byte", 64'({last_byte, last_dc}), 64'({8'h2A, 1'b0}));

      // Latency of byte_valid from the sampled 8th SCL rise, then pix_valid
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'h9A);
      lb = 8'hBC;
      for (int i = 7; i >= 1; i--) send_bit(lb[i], 1'b1);
      @(negedge clk);
      bus.scl = 1'b0;
      bus.sda = lb[0];
      repeat (4) @(negedge clk);
      bus.scl = 1'b1;
      n = 0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.byte_valid) found = 1'b1;
      end
      check("byte_latency", 64'(n), 64'(3));
      n = 0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.pix_valid) found = 1'b1;
      end
      check("pix_latency", 64'(n), 64'(1));
      check("lat_pix", 64'({bus.pix_x, bus.pix_y, bus.pix_data}), 64'({9'd0, 9'd0, 16'h9ABC}));
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
